percept_serial_if: RTL and testbench
====================================

Name: percept_serial_if

Overview:
Parametrised serial front end for one percept core. It receives framed bit-serial commands on a single line, decodes an address and a 2-bit command, and drives the percept shift/multiply-accumulate controls for exactly PAYLOAD_LEN bits. Non-addressed frames are skipped by length, so payload bits are never mistaken for start bits. It adds broadcast addressing, a serial read-back path, stop-bit checking and status outputs. It sits between the board-level serial line and the percept instance.

Parameters:
ADDR_W, 8, address field width in bits
PAYLOAD_LEN, 128, payload/readout bits per frame (>=1)
BCAST_ADDR, 8'hFF (ADDR_W bits), address accepted by every instance
CNT_W, $clog2(PAYLOAD_LEN+1), payload counter width

Ports:
clk  in  1  system clock, all logic on rising edge
nRst  in  1  reset; synchronous, active-high (1 = reset); name kept for port compatibility
serial_in  in  1  serial line, idles high, one bit per clk
address  in  ADDR_W  this instance's address, static
serial_out  out  1  read-back line, idles high
shift_in  out  1  percept: shift data_in into weights
shift_out  out  1  percept: shift result out onto data_out
mul_and_acc  out  1  percept: multiply data_in and accumulate
data_in  out  1  percept serial data
data_out  in  1  percept serial result
busy  out  1  high in every state except IDLE
frame_err  out  1  one-cycle pulse on bad stop bit
match  out  1  one-cycle pulse when a frame is accepted

Behaviour:
- Reset (nRst=1 at a clk edge): state=IDLE, counters=0, shift_in/shift_out/mul_and_acc/data_in/busy/frame_err/match=0, serial_out=1. Reset mid-frame aborts at once; no strobes on the following cycle.
- All outputs are registered.
- Frame: start bit 0, ADDR_W address bits MSB first, CMD[1:0] MSB first, PAYLOAD_LEN payload bit-times, stop bit 1.
- IDLE: serial_in=0 -> ADDR. Otherwise stay in IDLE.
- ADDR: shift serial_in into addr_sr for ADDR_W cycles -> CMD.
- CMD: shift 2 bits into cmd -> DECIDE.
- DECIDE (1 cycle, line ignored):
  - Accept when addr_sr==address or addr_sr==BCAST_ADDR, and cmd!=2'b11; pulse match.
  - Accepted cmd 00 -> LOAD; 01 -> MAC; 10 -> READ.
  - Otherwise -> SKIP.
  - cmd 10 with BCAST_ADDR is not accepted and goes to SKIP, to avoid read-back contention.
- LOAD/MAC: for PAYLOAD_LEN cycles, data_in<=serial_in and shift_in (LOAD) or mul_and_acc (MAC) <=1. Each strobe appears the cycle after its bit is sampled, aligned with data_in.
- READ: shift_out<=1 for PAYLOAD_LEN cycles; serial_out<=data_out each cycle, giving 1-cycle latency from data_out to serial_out. serial_out returns to 1 after the last bit. serial_in is ignored.
- SKIP: count PAYLOAD_LEN cycles with all strobes 0 and serial_in ignored.
- Counter: runs 0..PAYLOAD_LEN-1; the phase ends when count==PAYLOAD_LEN-1, so exactly PAYLOAD_LEN strobes occur. Count is cleared on entry to every payload state.
- STOP (1 cycle after LOAD/MAC/READ/SKIP): sample serial_in.
  - 1: return to IDLE.
  - 0: pulse frame_err and return to IDLE. This 0 is not treated as a new start bit.
- Strobes drop to 0 in the STOP cycle.
- Back-to-back frames: a start bit in the first cycle after STOP is detected normally.
- Total frame length: 1+ADDR_W+2+1+PAYLOAD_LEN+1 bit-times. The DECIDE slot must be transmitted as a don't-care bit.

Test Plan:
- Reset: hold nRst=1 for 3 cycles with serial_in toggling -> serial_out=1, all strobes/status=0, busy=0.
- LOAD: address=8'h2A; send start, 0x2A, cmd 00, DECIDE, 128 bits alternating 1010..., stop 1 -> match pulses once; shift_in high exactly 128 cycles; data_in reproduces the pattern 1 cycle late; frame_err=0.
- READ: address=8'h2A, cmd 10, data_out driven 0xA5 repeating -> shift_out high 128 cycles; serial_out equals data_out delayed 1 cycle, then 1.
- Non-match skip: address=8'h2A, frame to 0x15 cmd 00 whose payload is all 0 -> no strobes, no match; busy stays high through payload; next frame to 0x2A is accepted.
- Broadcast/reserved: frame to 0xFF cmd 01 -> mul_and_acc high 128 cycles. Frame to 0xFF cmd 10 and frame to 0x2A cmd 11 -> skipped, no strobes.
- Errors and reset: stop bit 0 -> frame_err pulses 1 cycle, state IDLE. Assert nRst at payload bit 40 of a LOAD -> shift_in=0 the next cycle, busy=0; a fresh frame completes with exactly 128 strobes.

Source files
------------

// File: rtl/percept_serial_if.sv
// Serial front end for one percept core: decodes framed bit-serial commands and
// drives the percept shift / multiply-accumulate / read-back controls for one payload.
module percept_serial_if #(
  parameter int                ADDR_W      = 8,
  parameter int                PAYLOAD_LEN = 128,
  parameter logic [ADDR_W-1:0] BCAST_ADDR  = '1,
  parameter int                CNT_W       = $clog2(PAYLOAD_LEN + 1)
) (
  input  logic              clk,
  input  logic              nRst,
  input  logic              serial_in,
  input  logic [ADDR_W-1:0] address,
  output logic              serial_out,
  output logic              shift_in,
  output logic              shift_out,
  output logic              mul_and_acc,
  output logic              data_in,
  input  logic              data_out,
  output logic              busy,
  output logic              frame_err,
  output logic              match
);

  localparam int BIT_W = (ADDR_W > 1) ? $clog2(ADDR_W + 1) : 1;

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_ADDR   = 4'd1;
  localparam logic [3:0] S_CMD    = 4'd2;
  localparam logic [3:0] S_DECIDE = 4'd3;
  localparam logic [3:0] S_LOAD   = 4'd4;
  localparam logic [3:0] S_MAC    = 4'd5;
  localparam logic [3:0] S_READ   = 4'd6;
  localparam logic [3:0] S_SKIP   = 4'd7;
  localparam logic [3:0] S_STOP   = 4'd8;

  localparam logic [CNT_W-1:0] PAY_LAST  = CNT_W'(PAYLOAD_LEN - 1);
  localparam logic [BIT_W-1:0] ADDR_LAST = BIT_W'(ADDR_W - 1);
  localparam logic [BIT_W-1:0] CMD_LAST  = BIT_W'(1);

  logic [3:0]        r_state;
  logic [BIT_W-1:0]  r_bit_cnt;
  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_addr_sr;
  logic [1:0]        r_cmd;
  logic              r_serial_out;
  logic              r_shift_in;
  logic              r_shift_out;
  logic              r_mul_and_acc;
  logic              r_data_in;
  logic              r_busy;
  logic              r_frame_err;
  logic              r_match;

  logic [3:0]        w_next;
  logic              w_accept;
  logic              w_payload;
  logic              w_header;

  assign w_payload = (r_state == S_LOAD) || (r_state == S_MAC) ||
                     (r_state == S_READ) || (r_state == S_SKIP);
  assign w_header  = (r_state == S_ADDR) || (r_state == S_CMD);

  // Broadcast read is refused so several instances never drive read-back at once.
  assign w_accept = ((r_addr_sr == address) || (r_addr_sr == BCAST_ADDR)) &&
                    (r_cmd != 2'b11) &&
                    !((r_addr_sr == BCAST_ADDR) && (r_cmd == 2'b10));

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (!serial_in) w_next = S_ADDR;
      S_ADDR:   if (r_bit_cnt == ADDR_LAST) w_next = S_CMD;
      S_CMD:    if (r_bit_cnt == CMD_LAST) w_next = S_DECIDE;
      S_DECIDE: begin
        if (!w_accept)            w_next = S_SKIP;
        else if (r_cmd == 2'b00)  w_next = S_LOAD;
        else if (r_cmd == 2'b01)  w_next = S_MAC;
        else                      w_next = S_READ;
      end
      S_LOAD, S_MAC, S_READ, S_SKIP: if (r_cnt == PAY_LAST) w_next = S_STOP;
      S_STOP:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (nRst) begin
      r_state       <= S_IDLE;
      r_bit_cnt     <= '0;
      r_cnt         <= '0;
      r_addr_sr     <= '0;
      r_cmd         <= '0;
      r_serial_out  <= 1'b1;
      r_shift_in    <= 1'b0;
      r_shift_out   <= 1'b0;
      r_mul_and_acc <= 1'b0;
      r_data_in     <= 1'b0;
      r_busy        <= 1'b0;
      r_frame_err   <= 1'b0;
      r_match       <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next != S_IDLE);

      // Counters restart whenever a phase is left, so every payload phase begins at 0.
      if (w_header && (w_next == r_state)) r_bit_cnt <= r_bit_cnt + 1'b1;
      else                                 r_bit_cnt <= '0;
      if (w_payload && (w_next == r_state)) r_cnt <= r_cnt + 1'b1;
      else                                  r_cnt <= '0;

      if (r_state == S_ADDR) r_addr_sr <= ADDR_W'({r_addr_sr, serial_in});
      if (r_state == S_CMD)  r_cmd     <= {r_cmd[0], serial_in};

      r_match       <= (r_state == S_DECIDE) && w_accept;
      r_frame_err   <= (r_state == S_STOP) && !serial_in;
      r_shift_in    <= (r_state == S_LOAD);
      r_mul_and_acc <= (r_state == S_MAC);
      r_shift_out   <= (r_state == S_READ);
      r_data_in     <= ((r_state == S_LOAD) || (r_state == S_MAC)) ? serial_in : 1'b0;
      r_serial_out  <= (r_state == S_READ) ? data_out : 1'b1;
    end
  end

  assign serial_out  = r_serial_out;
  assign shift_in    = r_shift_in;
  assign shift_out   = r_shift_out;
  assign mul_and_acc = r_mul_and_acc;
  assign data_in     = r_data_in;
  assign busy        = r_busy;
  assign frame_err   = r_frame_err;
  assign match       = r_match;

endmodule

// File: tb/tb_percept_serial_if.sv
// Bench for percept_serial_if: drives whole frames bit by bit and compares every
// cycle's outputs with values derived from the frame's address, command and payload.
module tb_percept_serial_if;

  localparam int ADDR_W = 8;
  localparam int P      = 128;
  localparam logic [7:0] IDLE_V = 8'b0000_0001;

  logic        clk = 1'b0;
  logic        nRst;
  logic        serial_in;
  logic [7:0]  address;
  logic        serial_out, shift_in, shift_out, mul_and_acc, data_in;
  logic        data_out;
  logic        busy, frame_err, match;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  percept_serial_if #(
    .ADDR_W      (ADDR_W),
    .PAYLOAD_LEN (P),
    .BCAST_ADDR  (8'hFF)
  ) dut (
    .clk         (clk),
    .nRst        (nRst),
    .serial_in   (serial_in),
    .address     (address),
    .serial_out  (serial_out),
    .shift_in    (shift_in),
    .shift_out   (shift_out),
    .mul_and_acc (mul_and_acc),
    .data_in     (data_in),
    .data_out    (data_out),
    .busy        (busy),
    .frame_err   (frame_err),
    .match       (match)
  );

  // Output vector: {busy, match, frame_err, shift_in, shift_out, mul_and_acc, data_in, serial_out}
  function automatic logic [7:0] obs();
    return {busy, match, frame_err, shift_in, shift_out, mul_and_acc, data_in, serial_out};
  endfunction

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%b exp=%b at t=%0t", tag, got, exp, $time);
  endtask

  task automatic step(input logic si, input logic dout);
    serial_in = si;
    data_out  = dout;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b1, 1'($urandom));
      check_eq("idle", obs(), IDLE_V);
    end
  endtask

  // pat: 0 = alternating 1010..., 1 = all zeros, 2 = random. abort_at >= 0 resets at that payload bit.
  task automatic send_frame(input logic [7:0] a, input logic [1:0] cmd, input int pat,
                            input logic stop, input int abort_at);
    logic       acc;
    logic       pay [P];
    logic [7:0] a5;
    logic [7:0] e;
    logic       dv;
    int         strobes;
    a5      = 8'hA5;
    strobes = 0;
    acc = ((a == address) || (a == 8'hFF)) && (cmd != 2'b11) &&
          !((a == 8'hFF) && (cmd == 2'b10));
    for (int k = 0; k < P; k++)
      pay[k] = (pat == 0) ? (k % 2 == 0) : (pat == 1) ? 1'b0 : 1'($urandom);

    step(1'b0, 1'($urandom));
    check_eq("start", obs(), 8'b1000_0001);
    for (int i = ADDR_W - 1; i >= 0; i--) begin
      step(a[i], 1'($urandom));
      check_eq("addr", obs(), 8'b1000_0001);
    end
    for (int i = 1; i >= 0; i--) begin
      step(cmd[i], 1'($urandom));
      check_eq("cmd", obs(), 8'b1000_0001);
    end
    step(1'($urandom), 1'($urandom));
    check_eq("decide", obs(), {1'b1, acc, 6'b000001});

    for (int k = 0; k < P; k++) begin
      if (k == abort_at) begin
        nRst = 1'b1;
        step(1'b1, 1'($urandom));
        check_eq("abort", obs(), IDLE_V);
        nRst = 1'b0;
        return;
      end
      dv = (acc && cmd == 2'b10) ? a5[7 - (k % 8)] : 1'($urandom);
      step(pay[k], dv);
      e = {1'b1, 1'b0, 1'b0,
           acc && (cmd == 2'b00),
           acc && (cmd == 2'b10),
           acc && (cmd == 2'b01),
           (acc && (cmd == 2'b00 || cmd == 2'b01)) ? pay[k] : 1'b0,
           (acc && cmd == 2'b10) ? dv : 1'b1};
      check_eq("payload", obs(), e);
      if (shift_in || shift_out || mul_and_acc) strobes++;
    end

    step(stop, 1'($urandom));
    check_eq("stop", obs(), {2'b00, ~stop, 5'b00001});
    check_eq("strobes", 8'(strobes), acc ? 8'(P) : 8'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ra;
    nRst      = 1'b1;
    serial_in = 1'b0;
    data_out  = 1'b0;
    address   = 8'h2A;
    for (int i = 0; i < 3; i++) begin
      step(1'(i % 2), 1'b0);
      check_eq("reset", obs(), IDLE_V);
    end
    nRst = 1'b0;
    idle_cycles(2);

    send_frame(8'h2A, 2'b00, 0, 1'b1, -1);  idle_cycles(2);
    send_frame(8'h2A, 2'b10, 2, 1'b1, -1);  idle_cycles(1);
    send_frame(8'h15, 2'b00, 1, 1'b1, -1);
    send_frame(8'h2A, 2'b00, 2, 1'b1, -1);  idle_cycles(1);
    send_frame(8'hFF, 2'b01, 2, 1'b1, -1);  idle_cycles(1);
    send_frame(8'hFF, 2'b10, 2, 1'b1, -1);
    send_frame(8'h2A, 2'b11, 2, 1'b1, -1);  idle_cycles(1);
    send_frame(8'h2A, 2'b00, 2, 1'b0, -1);
    send_frame(8'h2A, 2'b01, 2, 1'b1, -1);  idle_cycles(1);
    send_frame(8'h2A, 2'b00, 0, 1'b1, 40);  idle_cycles(2);
    send_frame(8'h2A, 2'b00, 2, 1'b1, -1);  idle_cycles(1);

    for (int n = 0; n < 8; n++) begin
      case ($urandom % 4)
        0:       ra = 8'h2A;
        1:       ra = 8'hFF;
        2:       ra = 8'h15;
        default: ra = 8'($urandom);
      endcase
      send_frame(ra, 2'($urandom), 2, 1'(($urandom % 4) != 0), -1);
      idle_cycles(int'($urandom % 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
